ex_mem_stage: RTL and testbench

- EX/MEM pipeline boundary directly downstream of the ALU in the RV32I core.
- Captures the ALU result and control for the memory stage, and resolves branches and jumps from the ALU flags.
- Issues a registered PC redirect to fetch and squashes the single wrong-path instruction behind a taken control transfer.
- Honours stall from the hazard unit and flush from the trap logic.

---
 rtl/ex_mem_stage.sv | 149 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary for the RV32I core: captures ALU result and control,
// resolves branches/jumps and issues a one-shot registered redirect with wrong-path squash.
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_slt,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic [2:0]      mem_funct3,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_misalign,
    output logic            mem_illegal,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    function automatic logic branch_cond(
        input logic [2:0]      funct3,
        input logic            zero,
        input logic            slt,
        input logic [XLEN-1:0] rs1,
        input logic [XLEN-1:0] rs2
    );
        logic ltu;
        ltu = (rs1 < rs2);
        case (funct3)
            3'b000:  branch_cond = zero;
            3'b001:  branch_cond = !zero;
            3'b100:  branch_cond = slt;
            3'b101:  branch_cond = !slt;
            3'b110:  branch_cond = ltu;
            3'b111:  branch_cond = !ltu;
            default: branch_cond = 1'b0;
        endcase
    endfunction

    logic            r_vld_p1;
    logic [XLEN-1:0] r_result_p1;
    logic [XLEN-1:0] r_store_data_p1;
    logic [4:0]      r_rd_p1;
    logic [2:0]      r_funct3_p1;
    logic            r_reg_write_p1;
    logic            r_mem_read_p1;
    logic            r_mem_write_p1;
    logic            r_misalign_p1;
    logic            r_illegal_p1;
    logic            r_squash_pending;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_live;
    logic            w_is_jump;
    logic            w_taken;
    logic            w_bad_funct3;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_do_redirect;
    logic            w_misalign;
    logic            w_illegal;

    // EX stage: resolve control transfer
    assign w_live        = ex_valid && !r_squash_pending;
    assign w_is_jump     = ex_is_jal || ex_is_jalr;
    assign w_bad_funct3  = (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
    assign w_taken       = w_is_jump ||
                           (ex_is_branch && branch_cond(ex_funct3, alu_zero, alu_slt, ex_rs1, ex_rs2));
    assign w_target      = ex_is_jalr ? {alu_out[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    assign w_link        = ex_pc + 32'd4;
    assign w_do_redirect = w_live && w_taken && !w_target[1];
    assign w_misalign    = w_live && w_taken && w_target[1];
    assign w_illegal     = w_live && ex_is_branch && w_bad_funct3;

    // EX -> MEM boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1         <= 1'b0;
            r_result_p1      <= '0;
            r_store_data_p1  <= '0;
            r_rd_p1          <= '0;
            r_funct3_p1      <= '0;
            r_reg_write_p1   <= 1'b0;
            r_mem_read_p1    <= 1'b0;
            r_mem_write_p1   <= 1'b0;
            r_misalign_p1    <= 1'b0;
            r_illegal_p1     <= 1'b0;
            r_squash_pending <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush || (!stall && !w_live)) begin
            r_vld_p1         <= 1'b0;
            r_reg_write_p1   <= 1'b0;
            r_mem_read_p1    <= 1'b0;
            r_mem_write_p1   <= 1'b0;
            r_misalign_p1    <= 1'b0;
            r_illegal_p1     <= 1'b0;
            r_squash_pending <= 1'b0;
        end else if (!stall) begin
            r_vld_p1         <= 1'b1;
            r_result_p1      <= w_is_jump ? w_link : alu_out;
            r_store_data_p1  <= ex_rs2;
            r_rd_p1          <= ex_rd;
            r_funct3_p1      <= ex_funct3;
            r_reg_write_p1   <= ex_reg_write;
            r_mem_read_p1    <= ex_mem_read;
            r_mem_write_p1   <= ex_mem_write;
            r_misalign_p1    <= w_misalign;
            r_illegal_p1     <= w_illegal;
            r_squash_pending <= w_do_redirect;
            if (w_do_redirect) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign mem_valid      = r_vld_p1;
    assign mem_result     = r_result_p1;
    assign mem_store_data = r_store_data_p1;
    assign mem_rd         = r_rd_p1;
    assign mem_funct3     = r_funct3_p1;
    assign mem_reg_write  = r_reg_write_p1;
    assign mem_mem_read   = r_mem_read_p1;
    assign mem_mem_write  = r_mem_write_p1;
    assign mem_misalign   = r_misalign_p1;
    assign mem_illegal    = r_illegal_p1;
    assign redirect       = r_squash_pending;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: capture, branch/jump resolution, squash,
// stall/flush/reset interaction and fault flags.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, alu_out;
    logic        alu_zero, alu_slt;
    logic        ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_valid;
    logic [31:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        mem_misalign, mem_illegal;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_slt(alu_slt),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_misalign(mem_misalign), .mem_illegal(mem_illegal),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0; alu_out = 0;
        alu_zero = 0; alu_slt = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},    {31'd0, mem_valid}, 32'd0);
        chk({tag, ".result"},   mem_result, 32'd0);
        chk({tag, ".sdata"},    mem_store_data, 32'd0);
        chk({tag, ".rd"},       {27'd0, mem_rd}, 32'd0);
        chk({tag, ".ctrl"},     {26'd0, mem_reg_write, mem_mem_read, mem_mem_write,
                                 mem_misalign, mem_illegal, mem_funct3 != 0}, 32'd0);
        chk({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
        chk({tag, ".rpc"},      redirect_pc, 32'd0);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_ex();
        step();
        chk_all_zero("reset");
        rst = 0;

        // ALU op capture
        ex_valid = 1; alu_out = 32'h10; ex_rd = 5; ex_reg_write = 1; ex_rs2 = 32'hCAFE0001;
        step();
        chk("add.valid", {31'd0, mem_valid}, 32'd1);
        chk("add.result", mem_result, 32'h10);
        chk("add.rd", {27'd0, mem_rd}, 32'd5);
        chk("add.regw", {31'd0, mem_reg_write}, 32'd1);
        chk("add.sdata", mem_store_data, 32'hCAFE0001);
        chk("add.redirect", {31'd0, redirect}, 32'd0);

        // Taken BEQ, then a wrong-path instruction
        clear_ex();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000; ex_pc = 32'h100; ex_imm = 32'h20; alu_zero = 1;
        step();
        chk("beq.redirect", {31'd0, redirect}, 32'd1);
        chk("beq.rpc", redirect_pc, 32'h120);
        chk("beq.valid", {31'd0, mem_valid}, 32'd1);
        clear_ex();
        ex_valid = 1; alu_out = 32'h55; ex_rd = 7; ex_reg_write = 1;
        step();
        chk("beq.squash.valid", {31'd0, mem_valid}, 32'd0);
        chk("beq.squash.regw", {31'd0, mem_reg_write}, 32'd0);
        chk("beq.redirect.drop", {31'd0, redirect}, 32'd0);

        // BLTU not taken (0xFFFFFFFF < 1 false unsigned)
        clear_ex();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b110; ex_rs1 = 32'hFFFFFFFF; ex_rs2 = 32'h1;
        ex_pc = 32'h300; ex_imm = 32'h8;
        step();
        chk("bltu.redirect", {31'd0, redirect}, 32'd0);
        chk("bltu.valid", {31'd0, mem_valid}, 32'd1);

        // BGEU taken
        ex_funct3 = 3'b111;
        step();
        chk("bgeu.redirect", {31'd0, redirect}, 32'd1);
        chk("bgeu.rpc", redirect_pc, 32'h308);

        // Taken BLT in the shadow slot: squashed, no second redirect
        clear_ex();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b100; alu_slt = 1; ex_pc = 32'h400; ex_imm = 32'h10;
        step();
        chk("shadow.valid", {31'd0, mem_valid}, 32'd0);
        chk("shadow.redirect", {31'd0, redirect}, 32'd0);
        step();
        chk("blt.redirect", {31'd0, redirect}, 32'd1);
        chk("blt.rpc", redirect_pc, 32'h410);
        clear_ex();
        step();
        chk("blt.drop", {31'd0, redirect}, 32'd0);

        // JALR
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h200; alu_out = 32'h305; ex_rd = 1; ex_reg_write = 1;
        step();
        chk("jalr.redirect", {31'd0, redirect}, 32'd1);
        chk("jalr.rpc", redirect_pc, 32'h304);
        chk("jalr.link", mem_result, 32'h204);

        // JAL at top of address space: squashed once, then captured
        clear_ex();
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFFFFFC; ex_imm = 32'h10; ex_rd = 1; ex_reg_write = 1;
        step();
        chk("jal.shadow.valid", {31'd0, mem_valid}, 32'd0);
        step();
        chk("jal.link.wrap", mem_result, 32'h0);
        chk("jal.redirect", {31'd0, redirect}, 32'd1);
        chk("jal.rpc", redirect_pc, 32'hC);

        // Stall while redirect pending
        clear_ex();
        stall = 1; ex_valid = 1; alu_out = 32'h77; ex_rd = 3; ex_reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.redirect", {31'd0, redirect}, 32'd1);
            chk("stall.rpc", redirect_pc, 32'hC);
            chk("stall.result", mem_result, 32'h0);
            chk("stall.valid", {31'd0, mem_valid}, 32'd1);
        end
        stall = 0;
        step();
        chk("unstall.valid", {31'd0, mem_valid}, 32'd0);
        chk("unstall.redirect", {31'd0, redirect}, 32'd0);

        // Flush with taken BNE
        clear_ex();
        flush = 1; ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; alu_zero = 0;
        ex_pc = 32'h500; ex_imm = 32'h4;
        step();
        chk("flush.valid", {31'd0, mem_valid}, 32'd0);
        chk("flush.redirect", {31'd0, redirect}, 32'd0);
        flush = 0;
        clear_ex();
        step();
        chk("flush.after", {31'd0, redirect}, 32'd0);

        // Reset while squash pending, with stall asserted
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000; alu_zero = 1; alu_out = 32'h99;
        ex_pc = 32'h600; ex_imm = 32'h0; ex_rs2 = 32'h1234;
        step();
        chk("pre_rst.redirect", {31'd0, redirect}, 32'd1);
        rst = 1; stall = 1;
        step();
        chk_all_zero("midrst");
        rst = 0; stall = 0;

        // Misaligned JAL target 0x102
        clear_ex();
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h100; ex_imm = 32'h2;
        step();
        chk("mis.flag", {31'd0, mem_misalign}, 32'd1);
        chk("mis.redirect", {31'd0, redirect}, 32'd0);
        chk("mis.valid", {31'd0, mem_valid}, 32'd1);
        chk("mis.link", mem_result, 32'h104);

        // Illegal branch funct3 010
        clear_ex();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b010; ex_pc = 32'h700; ex_imm = 32'h10; alu_zero = 1;
        step();
        chk("ill.flag", {31'd0, mem_illegal}, 32'd1);
        chk("ill.redirect", {31'd0, redirect}, 32'd0);
        chk("ill.valid", {31'd0, mem_valid}, 32'd1);
        chk("ill.mis", {31'd0, mem_misalign}, 32'd0);

        // Load then store field capture
        clear_ex();
        ex_valid = 1; ex_mem_read = 1; ex_funct3 = 3'b010; alu_out = 32'h1000; ex_rd = 9; ex_reg_write = 1;
        step();
        chk("ld.read", {31'd0, mem_mem_read}, 32'd1);
        chk("ld.funct3", {29'd0, mem_funct3}, 32'd2);
        chk("ld.rd", {27'd0, mem_rd}, 32'd9);
        chk("ld.illegal", {31'd0, mem_illegal}, 32'd0);
        clear_ex();
        ex_valid = 1; ex_mem_write = 1; ex_funct3 = 3'b001; alu_out = 32'h2002; ex_rs2 = 32'hBEEF;
        step();
        chk("st.write", {31'd0, mem_mem_write}, 32'd1);
        chk("st.read", {31'd0, mem_mem_read}, 32'd0);
        chk("st.sdata", mem_store_data, 32'hBEEF);
        chk("st.addr", mem_result, 32'h2002);

        // Idle input yields a bubble
        clear_ex();
        step();
        chk("idle.valid", {31'd0, mem_valid}, 32'd0);
        chk("idle.write", {31'd0, mem_mem_write}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
